// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the ARM-subset datapath.
// Decodes the instruction, evaluates its condition and owns the NZCV flags.
module multicycle_ctrl #(
  parameter int unsigned MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_control,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [3:0] flags,
  output logic       undef,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXECR  = 4'd2,
    S_EXECI  = 4'd3,
    S_ALUWB  = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic [3:0] cmd;
  logic       is_cmp;
  logic       set_s;
  logic [1:0] alu_dp;
  logic       cond_ok;
  logic       ready;
  logic       rd_pc;
  logic       fn, fz, fc, fv;

  assign cmd    = funct[4:1];
  assign is_cmp = (cmd == 4'b1010);
  assign set_s  = funct[0] | is_cmp;
  assign rd_pc  = (rd == 4'd15);
  assign ready  = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;
  assign {fn, fz, fc, fv} = flags_q;

  assign state = state_q;
  assign flags = flags_q;

  // DP command to ALU control; unknown commands execute as ADD
  always_comb begin
    unique case (cmd)
      4'b0100: alu_dp = 2'b00;
      4'b0010: alu_dp = 2'b01;
      4'b0000: alu_dp = 2'b10;
      4'b1100: alu_dp = 2'b11;
      4'b1010: alu_dp = 2'b01;
      default: alu_dp = 2'b00;
    endcase
  end

  // Condition check against the architectural flags
  always_comb begin
    unique case (cond)
      4'b0000: cond_ok = fz;
      4'b0001: cond_ok = !fz;
      4'b0010: cond_ok = fc;
      4'b0011: cond_ok = !fc;
      4'b0100: cond_ok = fn;
      4'b0101: cond_ok = !fn;
      4'b0110: cond_ok = fv;
      4'b0111: cond_ok = !fv;
      4'b1000: cond_ok = fc & !fz;
      4'b1001: cond_ok = !fc | fz;
      4'b1010: cond_ok = (fn == fv);
      4'b1011: cond_ok = (fn != fv);
      4'b1100: cond_ok = !fz & (fn == fv);
      4'b1101: cond_ok = fz | (fn != fv);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Immediate format and register-port steering follow the opcode
  always_comb begin
    unique case (op)
      2'b00:   imm_src = 2'b00;
      2'b01:   imm_src = 2'b01;
      2'b10:   imm_src = 2'b10;
      default: imm_src = 2'b00;
    endcase
    reg_src[0] = (op == 2'b10);
    reg_src[1] = (op == 2'b01) & !funct[0];
  end

  // Next state, per-state datapath controls and flag update
  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 2'b00;
    undef       = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = ready;
        pc_write   = ready;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        unique case (1'b1)
          op == 2'b00 &&  funct[5]: state_d = S_EXECI;
          op == 2'b00 && !funct[5]: state_d = S_EXECR;
          op == 2'b01:              state_d = S_MEMADR;
          op == 2'b10:              state_d = S_BRANCH;
          op == 2'b11: begin
            undef   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXECR, S_EXECI: begin
        alu_src_b   = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        alu_control = alu_dp;
        state_d     = S_ALUWB;
        if (set_s && cond_ok) begin
          if (alu_dp[1]) flags_d[3:2] = alu_flags[3:2];
          else           flags_d      = alu_flags;
        end
      end
      S_ALUWB: begin
        reg_write = cond_ok & !is_cmp;
        pc_write  = cond_ok & !is_cmp & rd_pc;
        state_d   = S_FETCH;
      end
      S_MEMADR: begin
        alu_src_b = 2'b01;
        state_d   = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = cond_ok;
        pc_write   = cond_ok & rd_pc;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        adr_src   = 1'b1;
        mem_write = cond_ok;
        if (ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = cond_ok;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State and flags registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

endmodule
